// File: rtl/reg_writeback_queue.sv
// In-order completion buffer feeding the register-file write port. Holds loads until memory
// returns, retires one entry per cycle and forwards not-yet-written results to operand fetch.
module reg_writeback_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ex_valid,
    output logic                         ex_ready,
    input  logic [4:0]                   ex_da,
    input  logic [DW-1:0]                ex_data,
    input  logic                         ex_is_load,
    input  logic                         mem_rvalid,
    input  logic [DW-1:0]                mem_rdata,
    input  logic [4:0]                   AA,
    input  logic [4:0]                   BA,
    output logic                         HA,
    output logic                         HB,
    output logic [DW-1:0]                FWD_A,
    output logic [DW-1:0]                FWD_B,
    output logic                         stall,
    output logic                         RW,
    output logic [4:0]                   DA,
    output logic [DW-1:0]                BUS_D,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] rdy_q;
    logic [4:0]       da_q   [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;

    logic          store;
    logic          ret;
    logic          fill_found;
    logic [PW-1:0] fill_idx;
    logic          stall_a;
    logic          stall_b;

    assign ex_ready = (count_q != CW'(DEPTH));
    assign count    = count_q;

    // ALU results to R0 complete the handshake but never occupy an entry.
    assign store = !rst && ex_valid && ex_ready && (ex_is_load || (ex_da != 5'd0));
    assign ret   = valid_q[head_q] && rdy_q[head_q];

    // Oldest unfilled entry, scanning from the head; this is the load the next response fills.
    always_comb begin
        fill_found = 1'b0;
        fill_idx   = head_q;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (!fill_found && (CW'(k) < count_q) && !rdy_q[head_q + PW'(k)]) begin
                fill_found = 1'b1;
                fill_idx   = head_q + PW'(k);
            end
        end
    end

    // Returns {hit, stall, data}; youngest matching entry wins, then the in-flight write.
    function automatic logic [DW+1:0] fwd_lookup(input logic [4:0] addr);
        logic          hit;
        logic          stl;
        logic          found;
        logic [DW-1:0] d;
        logic [PW-1:0] idx;
        hit   = 1'b0;
        stl   = 1'b0;
        found = 1'b0;
        d     = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            idx = head_q + PW'(k);
            if (!found && (addr != 5'd0) && (CW'(k) < count_q) && (da_q[idx] == addr)) begin
                found = 1'b1;
                hit   = rdy_q[idx];
                stl   = !rdy_q[idx];
                d     = rdy_q[idx] ? data_q[idx] : '0;
            end
        end
        if (!found && (addr != 5'd0) && RW && (DA == addr)) begin
            hit = 1'b1;
            d   = BUS_D;
        end
        return {hit, stl, d};
    endfunction

    assign {HA, stall_a, FWD_A} = fwd_lookup(AA);
    assign {HB, stall_b, FWD_B} = fwd_lookup(BA);
    assign stall = stall_a || stall_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            rdy_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            RW      <= 1'b0;
            DA      <= '0;
            BUS_D   <= '0;
            err     <= 1'b0;
        end else begin
            if (store) begin
                valid_q[tail_q] <= 1'b1;
                rdy_q[tail_q]   <= !ex_is_load;
                da_q[tail_q]    <= ex_da;
                data_q[tail_q]  <= ex_is_load ? '0 : ex_data;
                tail_q          <= tail_q + PW'(1);
            end
            if (mem_rvalid) begin
                if (fill_found) begin
                    data_q[fill_idx] <= mem_rdata;
                    rdy_q[fill_idx]  <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
            if (ret) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
                RW              <= (da_q[head_q] != 5'd0);
                DA              <= da_q[head_q];
                BUS_D           <= data_q[head_q];
            end else begin
                RW <= 1'b0;
            end
            count_q <= count_q + CW'(store) - CW'(ret);
        end
    end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue; a scoreboard of expected register writes is
// filled as stimulus is driven and drained whenever the write port fires.
module tb_reg_writeback_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_da;
    logic [31:0] ex_data;
    logic        ex_is_load;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  AA;
    logic [4:0]  BA;
    logic        HA;
    logic        HB;
    logic [31:0] FWD_A;
    logic [31:0] FWD_B;
    logic        stall;
    logic        RW;
    logic [4:0]  DA;
    logic [31:0] BUS_D;
    logic [2:0]  count;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];

    reg_writeback_queue #(.DEPTH(4), .DW(32)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_da(ex_da),
        .ex_data(ex_data), .ex_is_load(ex_is_load), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .AA(AA), .BA(BA), .HA(HA), .HB(HB), .FWD_A(FWD_A),
        .FWD_B(FWD_B), .stall(stall), .RW(RW), .DA(DA), .BUS_D(BUS_D), .count(count),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Move one cycle past the next rising edge and check any register write against the scoreboard.
    task automatic next_cycle();
        logic [36:0] e;
        @(posedge clk);
        #1;
        if (RW === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL sb_unexpected_write observed DA=%0d BUS_D=%h expected none", DA, BUS_D);
            end else begin
                e = exp_q.pop_front();
                assert ({DA, BUS_D} === e) else begin
                    errors++;
                    $error("FAIL sb_write observed DA=%0d BUS_D=%h expected DA=%0d BUS_D=%h",
                           DA, BUS_D, e[36:32], e[31:0]);
                end
            end
        end
    endtask

    task automatic drive_ex(input logic v, input logic [4:0] da, input logic [31:0] d,
                            input logic ld);
        ex_valid   = v;
        ex_da      = da;
        ex_data    = d;
        ex_is_load = ld;
    endtask

    initial begin
        rst = 1'b1;
        drive_ex(1'b0, 5'd0, 32'h0, 1'b0);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        AA = '0;
        BA = '0;
        repeat (2) next_cycle();
        rst = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_rw", RW, 0);
        chk("rst_da", DA, 0);
        chk("rst_bus_d", BUS_D, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", stall, 0);

        // ALU R5 forwarded while queued and while being written
        drive_ex(1'b1, 5'd5, 32'h1234, 1'b0);
        AA = 5'd5;
        exp_q.push_back({5'd5, 32'h1234});
        #1;
        chk("t1_hit_c0", HA, 0);
        next_cycle();
        drive_ex(1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        chk("t1_hit_c1", HA, 1);
        chk("t1_fwd_c1", FWD_A, 32'h1234);
        chk("t1_rw_c1", RW, 0);
        chk("t1_count_c1", count, 1);
        next_cycle();
        #1;
        chk("t1_rw_c2", RW, 1);
        chk("t1_da_c2", DA, 5);
        chk("t1_hit_c2", HA, 1);
        chk("t1_fwd_c2", FWD_A, 32'h1234);
        chk("t1_count_c2", count, 0);
        next_cycle();
        #1;
        chk("t1_rw_c3", RW, 0);
        chk("t1_hit_c3", HA, 0);
        chk("t1_fwd_c3", FWD_A, 0);

        // Load R3 then ALU R4; load-use stall until the fill edge
        AA = 5'd3;
        drive_ex(1'b1, 5'd3, 32'hBAD, 1'b1);
        exp_q.push_back({5'd3, 32'hDEAD});
        next_cycle();
        drive_ex(1'b1, 5'd4, 32'h44, 1'b0);
        exp_q.push_back({5'd4, 32'h44});
        #1;
        chk("t2_stall_a1", stall, 1);
        chk("t2_hit_a1", HA, 0);
        next_cycle();
        drive_ex(1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        chk("t2_stall_a2", stall, 1);
        chk("t2_count_a2", count, 2);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            #1;
            chk("t2_stall_wait", stall, 1);
            chk("t2_rw_wait", RW, 0);
        end
        next_cycle();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD;
        #1;
        chk("t2_stall_fillcyc", stall, 1);
        chk("t2_hit_fillcyc", HA, 0);
        next_cycle();
        mem_rvalid = 1'b0;
        #1;
        chk("t2_stall_after", stall, 0);
        chk("t2_hit_after", HA, 1);
        chk("t2_fwd_after", FWD_A, 32'hDEAD);
        chk("t2_rw_after", RW, 0);
        next_cycle();
        #1;
        chk("t2_rw_r3", RW, 1);
        chk("t2_da_r3", DA, 3);
        next_cycle();
        #1;
        chk("t2_rw_r4", RW, 1);
        chk("t2_da_r4", DA, 4);
        next_cycle();
        #1;
        chk("t2_rw_done", RW, 0);
        chk("t2_count_done", count, 0);
        AA = 5'd0;

        // Fill to DEPTH with loads; full stays not-ready even while retiring
        for (int i = 0; i < 4; i++) begin
            drive_ex(1'b1, 5'(8 + i), 32'h0, 1'b1);
            exp_q.push_back({5'(8 + i), 32'(32'hA0 + i)});
            next_cycle();
        end
        drive_ex(1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        chk("t3_count_full", count, 4);
        chk("t3_ready_full", ex_ready, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hA0;
        next_cycle();
        mem_rvalid = 1'b0;
        drive_ex(1'b1, 5'd12, 32'hEE, 1'b0);
        #1;
        chk("t3_ready_retcyc", ex_ready, 0);
        chk("t3_count_retcyc", count, 4);
        next_cycle();
        drive_ex(1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        chk("t3_ready_after", ex_ready, 1);
        chk("t3_count_after", count, 3);
        chk("t3_rw_after", RW, 1);
        for (int i = 1; i < 4; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'(32'hA0 + i);
            next_cycle();
        end
        mem_rvalid = 1'b0;
        repeat (4) next_cycle();
        #1;
        chk("t3_count_drained", count, 0);

        // Two writes to R7 queued behind an unfilled load; youngest forwards
        drive_ex(1'b1, 5'd2, 32'h0, 1'b1);
        exp_q.push_back({5'd2, 32'h55});
        next_cycle();
        drive_ex(1'b1, 5'd7, 32'h1, 1'b0);
        exp_q.push_back({5'd7, 32'h1});
        next_cycle();
        drive_ex(1'b1, 5'd7, 32'h2, 1'b0);
        exp_q.push_back({5'd7, 32'h2});
        next_cycle();
        drive_ex(1'b0, 5'd0, 32'h0, 1'b0);
        BA = 5'd7;
        AA = 5'd2;
        #1;
        chk("t4_hit_b", HB, 1);
        chk("t4_fwd_b", FWD_B, 32'h2);
        chk("t4_hit_a", HA, 0);
        chk("t4_stall", stall, 1);
        chk("t4_count", count, 3);
        chk("t4_rw_blocked", RW, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55;
        next_cycle();
        mem_rvalid = 1'b0;
        AA = 5'd0;
        BA = 5'd0;
        repeat (4) next_cycle();
        #1;
        chk("t4_count_drained", count, 0);

        // R0 destinations: ALU dropped, load stored and consumed but never written
        drive_ex(1'b1, 5'd0, 32'h99, 1'b0);
        #1;
        chk("t5_ready", ex_ready, 1);
        next_cycle();
        drive_ex(1'b1, 5'd0, 32'h0, 1'b1);
        #1;
        chk("t5_alu_r0_count", count, 0);
        next_cycle();
        drive_ex(1'b0, 5'd0, 32'h0, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h77;
        #1;
        chk("t5_ld_r0_count", count, 1);
        next_cycle();
        mem_rvalid = 1'b0;
        #1;
        chk("t5_r0_no_hit", HA, 0);
        chk("t5_r0_no_fwd", FWD_A, 0);
        chk("t5_rw_c3", RW, 0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            chk("t5_rw_never", RW, 0);
        end
        chk("t5_count_end", count, 0);
        chk("t5_err_end", err, 0);

        // Orphan response sets sticky err; reset clears everything
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1;
        next_cycle();
        mem_rvalid = 1'b0;
        #1;
        chk("t6_err_set", err, 1);
        next_cycle();
        #1;
        chk("t6_err_sticky", err, 1);
        drive_ex(1'b1, 5'd1, 32'h0, 1'b1);
        next_cycle();
        drive_ex(1'b1, 5'd2, 32'h2, 1'b0);
        next_cycle();
        drive_ex(1'b1, 5'd3, 32'h3, 1'b0);
        next_cycle();
        drive_ex(1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        chk("t6_count_3", count, 3);
        rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5;
        drive_ex(1'b1, 5'd6, 32'h6, 1'b0);
        next_cycle();
        rst = 1'b0;
        mem_rvalid = 1'b0;
        drive_ex(1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        chk("t6_rw_rst", RW, 0);
        chk("t6_count_rst", count, 0);
        chk("t6_ready_rst", ex_ready, 1);
        chk("t6_err_rst", err, 0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            chk("t6_rw_quiet", RW, 0);
            chk("t6_count_quiet", count, 0);
        end

        chk("sb_empty", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
